// File: rtl/str_pkg.sv
// -----------------------------------------------------------------------------
// str_pkg
//   Shared definitions for the stream frame arbiter slice.
//   - DW_DEFAULT / NCH_DEFAULT : default sample width and channel count
//   - clog2()                  : ceiling log2, used to size channel-ID fields
//   - arb_state_e              : arbiter FSM states
// -----------------------------------------------------------------------------
package str_pkg;

  localparam int DW_DEFAULT  = 24;
  localparam int NCH_DEFAULT = 4;

  // Ceiling log2; clog2(1) = 0. Usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // IDLE is the single arbitration (bubble) cycle between frames;
  // BUSY holds the grant until the tlast beat has been accepted.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage : str_pkg

// File: rtl/str_frame_arbiter_if.sv
// -----------------------------------------------------------------------------
// str_frame_arbiter_if
//   Bundles the NCH input AXI-Stream channels and the merged output stream.
//   - s_axis_tdata  : NCH*DW, channel k in bits [k*DW +: DW]
//   - s_axis_tvalid : NCH, per-channel valid
//   - s_axis_tlast  : NCH, per-channel end-of-frame
//   - s_axis_tready : NCH, per-channel ready (driven by the arbiter)
//   - m_axis_tdata  : DW, merged data
//   - m_axis_tid    : IDW, source channel of the current beat
//   - m_axis_tlast  : end of frame
//   - m_axis_tvalid : output valid
//   - m_axis_tready : downstream ready
//   Modports:
//   - master : the arbiter (consumes the channels, drives the merged stream)
//   - slave  : the surroundings (channel sources and downstream sink)
// -----------------------------------------------------------------------------
interface str_frame_arbiter_if
  import str_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int NCH = NCH_DEFAULT,
  parameter int IDW = clog2(NCH)
);

  logic [NCH*DW-1:0] s_axis_tdata;
  logic [NCH-1:0]    s_axis_tvalid;
  logic [NCH-1:0]    s_axis_tlast;
  logic [NCH-1:0]    s_axis_tready;

  logic [DW-1:0]     m_axis_tdata;
  logic [IDW-1:0]    m_axis_tid;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tid,
    output m_axis_tlast,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tid,
    input  m_axis_tlast,
    input  m_axis_tvalid,
    output m_axis_tready
  );

endinterface : str_frame_arbiter_if

// File: rtl/str_frame_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin search: returns the first set bit of req,
//   scanning upward from ptr and wrapping from NCH-1 back to 0.
//   - req     : NCH, request vector
//   - ptr     : IDW, starting index (highest priority)
//   - gnt_idx : IDW, index of the selected requester (0 when none)
//   - gnt_any : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import str_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  parameter int IDW = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);

  always_comb begin
    int cand;
    // NOTE: every output of a combinational block gets a value before any
    // branch, otherwise paths that skip the assignment infer a latch.
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int i = 0; i < NCH; i++) begin
      // ptr + i can pass NCH at most once, so one subtraction wraps it.
      cand = int'(ptr) + i;
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(cand);
      end
    end
  end

endmodule : rr_pick

// File: rtl/str_frame_arbiter.sv
// -----------------------------------------------------------------------------
// str_frame_arbiter
//   Frame-granular round-robin merge of NCH AXI-Stream channels into one
//   stream. A grant is held from the first beat through the tlast beat, so
//   frames never interleave; each output beat carries its source channel in
//   m_axis_tid. One arbitration cycle (IDLE) separates frames; within a frame
//   the rate is one beat per cycle through a one-deep output register slice.
//   Ports:
//   - clk, rst  : clock, asynchronous active-high reset
//   - enable    : run control, looked at only when arbitrating
//   - ch_mask   : per-channel participation, looked at only when arbitrating
//   - bus       : str_frame_arbiter_if.master (input channels + merged output)
//   - busy      : a grant is held (mid-frame)
//   - frame_cnt : frames completed on the output, wraps at 2^32
// -----------------------------------------------------------------------------
module str_frame_arbiter
  import str_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int NCH = NCH_DEFAULT,
  parameter int IDW = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NCH-1:0]       ch_mask,
  str_frame_arbiter_if.master  bus,
  output logic                 busy,
  output logic [31:0]          frame_cnt
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  arb_state_e     state_q, state_d;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] grant_inc;

  logic [NCH-1:0] req;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;

  logic [NCH-1:0] tready_c;
  logic           slot_free;
  logic           beat_ok;
  logic           beat_last;
  logic [DW-1:0]  beat_data;
  logic           frame_done;

  logic [DW-1:0]  m_tdata_q;
  logic [IDW-1:0] m_tid_q;
  logic           m_tlast_q;
  logic           m_tvalid_q;
  logic [31:0]    frame_cnt_q;

  // ---------------------------------------------------------------------------
  // Arbitration: enable and ch_mask only matter here, so changing them
  // mid-frame never truncates the frame in flight.
  // ---------------------------------------------------------------------------
  assign req = bus.s_axis_tvalid & ch_mask;

  rr_pick #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // The slice can take a beat when it is empty or is being drained this cycle.
  assign slot_free = !m_tvalid_q || bus.m_axis_tready;

  assign beat_data = bus.s_axis_tdata[int'(grant_q)*DW +: DW];
  assign beat_last = bus.s_axis_tlast[grant_q];
  assign grant_inc = (int'(grant_q) == NCH - 1) ? '0 : grant_q + IDW'(1);

  // ---------------------------------------------------------------------------
  // FSM: next state and per-channel ready
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    tready_c = '0;
    beat_ok  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && pick_any) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Only the granted channel ever sees ready; all others must hold.
        tready_c[grant_q] = slot_free;
        beat_ok           = bus.s_axis_tvalid[grant_q] && slot_free;
        if (beat_ok && beat_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state, grant and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && state_d == ST_BUSY) begin
        grant_q <= pick_idx;
      end
      // The channel just served drops to lowest priority for the next search.
      if (beat_ok && beat_last) begin
        rr_ptr_q <= grant_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register slice (one deep). A load wins over a drain, which gives
  // full throughput when both happen in the same cycle. With valid high and
  // ready low nothing is loaded, so the outputs hold.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tid_q    <= '0;
      m_tlast_q  <= 1'b0;
    end else if (beat_ok) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= beat_data;
      m_tid_q    <= grant_q;
      m_tlast_q  <= beat_last;
    end else if (bus.m_axis_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Completed-frame counter, counted at the output handshake; wraps naturally.
  // ---------------------------------------------------------------------------
  assign frame_done = m_tvalid_q && bus.m_axis_tready && m_tlast_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.s_axis_tready = tready_c;
  assign bus.m_axis_tdata  = m_tdata_q;
  assign bus.m_axis_tid    = m_tid_q;
  assign bus.m_axis_tlast  = m_tlast_q;
  assign bus.m_axis_tvalid = m_tvalid_q;
  assign busy              = (state_q == ST_BUSY);
  assign frame_cnt         = frame_cnt_q;

endmodule : str_frame_arbiter

// File: tb/tb_str_frame_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_str_frame_arbiter
//   Per-channel source queues feed the DUT; expected output beats are pushed
//   to a scoreboard queue as frames are offered and popped on each output
//   handshake. A vector table covers round-robin/mask/enable selection with
//   1-beat frames; hand-written sequences cover the multi-cycle cases.
// -----------------------------------------------------------------------------
module tb_str_frame_arbiter;
  import str_pkg::*;

  localparam int DW  = 24;
  localparam int NCH = 4;
  localparam int IDW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0]  data;
    logic [IDW-1:0] tid;
    logic           last;
  } exp_t;

  // One selection vector: offer a 1-beat frame on every channel in 'offer',
  // then expect n frames whose tids are listed left to right in 'seq'.
  typedef struct {
    logic           en;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] offer;
    int             n;
    logic [7:0]     seq;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  ch_mask;
  logic        busy;
  logic [31:0] frame_cnt;

  str_frame_arbiter_if #(.DW(DW), .NCH(NCH), .IDW(IDW)) bus ();

  str_frame_arbiter #(
    .DW  (DW),
    .NCH (NCH),
    .IDW (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ch_mask   (ch_mask),
    .bus       (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  int         cyc;
  beat_t      src_q [NCH][$];
  exp_t       exp_q [$];
  int         out_cyc [$];
  logic [1:0] out_tid [$];
  vec_t       vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present the head of every source queue to the DUT.
  task automatic drive();
    beat_t b;
    for (int k = 0; k < NCH; k++) begin
      if (src_q[k].size() > 0) begin
        b = src_q[k][0];
        bus.s_axis_tvalid[k]          = 1'b1;
        bus.s_axis_tdata[k*DW +: DW]  = b.data;
        bus.s_axis_tlast[k]           = b.last;
      end else begin
        bus.s_axis_tvalid[k] = 1'b0;
        bus.s_axis_tlast[k]  = 1'b0;
      end
    end
  endtask

  task automatic flush();
    for (int k = 0; k < NCH; k++) src_q[k].delete();
    drive();
  endtask

  task automatic push_frame(input int k, input int base, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = DW'(base + i);
      b.last = (i == len - 1);
      src_q[k].push_back(b);
    end
  endtask

  task automatic expect_frame(input int k, input int base, input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.data = DW'(base + i);
      e.tid  = IDW'(k);
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample handshakes at the falling edge, advance sources after
  // the rising edge. Called and returns at rising edge + 1ns.
  task automatic cycle();
    logic [NCH-1:0] fire;
    exp_t e;
    @(negedge clk);
    fire = bus.s_axis_tvalid & bus.s_axis_tready;
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      out_cyc.push_back(cyc);
      out_tid.push_back(bus.m_axis_tid);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data 0x%0h tid %0d, want no beat (cycle %0d)",
                 bus.m_axis_tdata, bus.m_axis_tid, cyc);
      end else begin
        e = exp_q.pop_front();
        check("out_tdata", 32'(bus.m_axis_tdata), 32'(e.data));
        check("out_tid",   32'(bus.m_axis_tid),   32'(e.tid));
        check("out_tlast", 32'(bus.m_axis_tlast), 32'(e.last));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NCH; k++) begin
      if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until_empty(input string name, input int max);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      cycle();
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    enable             = 1'b0;
    ch_mask            = '0;
    bus.m_axis_tready  = 1'b1;
    flush();
    exp_q.delete();
    out_cyc.delete();
    out_tid.delete();
    repeat (2) @(negedge clk);
    check("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'h0);
    check("rst_m_tdata",  32'(bus.m_axis_tdata),  32'h0);
    check("rst_m_tid",    32'(bus.m_axis_tid),    32'h0);
    check("rst_m_tlast",  32'(bus.m_axis_tlast),  32'h0);
    check("rst_s_tready", 32'(bus.s_axis_tready), 32'h0);
    check("rst_busy",     32'(busy),              32'h0);
    check("rst_frame_cnt", frame_cnt,             32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a given beat to be sitting on the output.
  task automatic wait_out(input string name, input logic [DW-1:0] data, input int max);
    int n;
    n = 0;
    while (!(bus.m_axis_tvalid && bus.m_axis_tdata == data) && n < max) begin
      cycle();
      n++;
    end
    check({name, "_seen"}, 32'(bus.m_axis_tdata), 32'(data));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ch;
    total              = 0;
    bad                = 0;
    cyc                = 0;
    rst                = 1'b1;
    enable             = 1'b0;
    ch_mask            = '0;
    bus.s_axis_tdata   = '0;
    bus.s_axis_tvalid  = '0;
    bus.s_axis_tlast   = '0;
    bus.m_axis_tready  = 1'b1;

    // en, mask, offer, n, tid order (rr_ptr evolves from 0 across the table)
    vecs[0] = '{1'b1, 4'b1111, 4'b0001, 1, {2'd0, 2'd0, 2'd0, 2'd0}}; // ptr 0 -> 1
    vecs[1] = '{1'b1, 4'b1111, 4'b1111, 4, {2'd1, 2'd2, 2'd3, 2'd0}}; // ptr -> 1
    vecs[2] = '{1'b1, 4'b0101, 4'b1111, 2, {2'd2, 2'd0, 2'd0, 2'd0}}; // ptr -> 1
    vecs[3] = '{1'b0, 4'b1111, 4'b1111, 0, {2'd0, 2'd0, 2'd0, 2'd0}}; // stopped
    vecs[4] = '{1'b1, 4'b1000, 4'b1001, 1, {2'd3, 2'd0, 2'd0, 2'd0}}; // ptr -> 0
    vecs[5] = '{1'b1, 4'b1111, 4'b0110, 2, {2'd1, 2'd2, 2'd0, 2'd0}}; // ptr -> 3
    vecs[6] = '{1'b1, 4'b1111, 4'b0001, 1, {2'd0, 2'd0, 2'd0, 2'd0}}; // wrap 3 -> 0
    vecs[7] = '{1'b1, 4'b0000, 4'b1111, 0, {2'd0, 2'd0, 2'd0, 2'd0}}; // all masked

    // ---- single channel, 3-beat frame ----
    do_reset();
    enable  = 1'b1;
    ch_mask = 4'b1111;
    push_frame(0, 1, 3);
    expect_frame(0, 1, 3);
    drive();
    run_until_empty("single", 20);
    run(2);
    check("single_frame_cnt", frame_cnt, 32'd1);
    check("single_busy", 32'(busy), 32'h0);
    check("single_rr_ptr", 32'(dut.rr_ptr_q), 32'd1);

    // ---- selection table ----
    do_reset();
    for (int v = 0; v < 8; v++) begin
      enable  = vecs[v].en;
      ch_mask = vecs[v].mask;
      for (int k = 0; k < NCH; k++) begin
        if (vecs[v].offer[k]) push_frame(k, (v + 1) * 256 + k, 1);
      end
      for (int j = 0; j < vecs[v].n; j++) begin
        ch = int'(vecs[v].seq[7 - 2*j -: 2]);
        expect_frame(ch, (v + 1) * 256 + ch, 1);
      end
      drive();
      run(14);
      check($sformatf("vec%0d_pending", v), 32'(exp_q.size()), 32'h0);
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'h0);
      flush();
    end

    // ---- round-robin fairness, 2-beat frames on all channels ----
    do_reset();
    enable  = 1'b1;
    ch_mask = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NCH; k++) begin
        push_frame(k, 16'h1000 + r * 256 + k * 16, 2);
        expect_frame(k, 16'h1000 + r * 256 + k * 16, 2);
      end
    end
    drive();
    run_until_empty("fair", 60);
    check("fair_beats", 32'(out_tid.size()), 32'd16);
    if (out_tid.size() == 16) begin
      for (int f = 0; f < 8; f++) begin
        check($sformatf("fair_same_tid%0d", f), 32'(out_tid[2*f+1]), 32'(out_tid[2*f]));
        check($sformatf("fair_in_frame_gap%0d", f), 32'(out_cyc[2*f+1] - out_cyc[2*f]), 32'd1);
        if (f < 7) begin
          check($sformatf("fair_bubble%0d", f), 32'(out_cyc[2*f+2] - out_cyc[2*f+1]), 32'd2);
        end
      end
    end

    // ---- backpressure on a 4-beat ch2 frame ----
    do_reset();
    enable  = 1'b1;
    ch_mask = 4'b1111;
    push_frame(2, 16'h200, 4);
    expect_frame(2, 16'h200, 4);
    drive();
    wait_out("bp_beat2", 24'h201, 20);
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_hold_tvalid", 32'(bus.m_axis_tvalid), 32'h1);
      check("bp_hold_tdata",  32'(bus.m_axis_tdata),  32'h201);
      check("bp_hold_tid",    32'(bus.m_axis_tid),    32'd2);
      check("bp_hold_tlast",  32'(bus.m_axis_tlast),  32'h0);
      check("bp_s_tready2",   32'(bus.s_axis_tready[2]), 32'h0);
    end
    bus.m_axis_tready = 1'b1;
    run_until_empty("bp", 20);
    run(2);
    check("bp_beats", 32'(out_tid.size()), 32'd4);
    check("bp_frame_cnt", frame_cnt, 32'd1);

    // ---- ch_mask = 0101 with all channels valid ----
    do_reset();
    enable  = 1'b1;
    ch_mask = 4'b0101;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NCH; k++) push_frame(k, 16'h3000 + r * 256 + k * 16, 2);
      expect_frame(0, 16'h3000 + r * 256, 2);
      expect_frame(2, 16'h3000 + r * 256 + 32, 2);
    end
    drive();
    run_until_empty("mask", 40);
    run(4);
    check("mask_beats", 32'(out_tid.size()), 32'd8);
    check("mask_busy", 32'(busy), 32'h0);
    flush();

    // ---- enable dropped mid-frame on ch2 ----
    do_reset();
    enable  = 1'b1;
    ch_mask = 4'b1111;
    push_frame(2, 16'h400, 3);
    push_frame(2, 16'h410, 3);
    expect_frame(2, 16'h400, 3);
    drive();
    wait_out("en_first", 24'h400, 20);
    enable = 1'b0;
    run_until_empty("en", 20);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("en_idle_s_tready", 32'(bus.s_axis_tready), 32'h0);
    end
    check("en_busy", 32'(busy), 32'h0);
    check("en_m_tvalid", 32'(bus.m_axis_tvalid), 32'h0);
    check("en_frame_cnt", frame_cnt, 32'd1);
    check("en_second_pending", 32'(src_q[2].size()), 32'd3);
    flush();

    // ---- reset in the middle of a 3-beat ch1 frame ----
    do_reset();
    enable  = 1'b1;
    ch_mask = 4'b1111;
    push_frame(1, 16'h500, 3);
    expect_frame(1, 16'h500, 3);
    drive();
    wait_out("mid_rst_beat1", 24'h500, 20);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'h0);
    check("mid_rst_m_tdata",  32'(bus.m_axis_tdata),  32'h0);
    check("mid_rst_m_tid",    32'(bus.m_axis_tid),    32'h0);
    check("mid_rst_m_tlast",  32'(bus.m_axis_tlast),  32'h0);
    check("mid_rst_s_tready", 32'(bus.s_axis_tready), 32'h0);
    check("mid_rst_busy",     32'(busy),              32'h0);
    exp_q.delete();
    flush();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_frame_cnt", frame_cnt, 32'h0);
    push_frame(1, 16'h510, 1);
    push_frame(0, 16'h520, 1);
    expect_frame(0, 16'h520, 1);
    expect_frame(1, 16'h510, 1);
    drive();
    run_until_empty("post_rst", 20);

    // ---- frame counter wrap and 1-beat frame on ch3 ----
    do_reset();
    enable  = 1'b1;
    ch_mask = 4'b1111;
    push_frame(1, 16'h600, 1);
    expect_frame(1, 16'h600, 1);
    drive();
    run_until_empty("wrap_pre", 10);
    run(2);
    check("wrap_pre_rr_ptr", 32'(dut.rr_ptr_q), 32'd2);
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    #2;
    release dut.frame_cnt_q;
    push_frame(3, 16'h610, 1);
    expect_frame(3, 16'h610, 1);
    drive();
    run_until_empty("wrap", 10);
    run(2);
    check("wrap_frame_cnt", frame_cnt, 32'h0);
    check("wrap_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    check("wrap_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_str_frame_arbiter
